ysyx_24070016_exu_ctrl: RTL and testbench
=========================================

// Module: ysyx_24070016_exu_ctrl
// PURPOSE
//  Sequencer wrapped around the EXU datapath. It turns the single-cycle ALU path into a valid/ready pipeline stage between IDU and WBU.
//  Single-cycle ops capture the combinational ALU result. Multi-cycle ops (mul/div) are handed to an iterative unit via start/done/abort.
//  ebreak is detected here and halts the core. The block also counts retired instructions.
// PARAMETERS
//  XLEN        32    datapath width
//  MD_TIMEOUT  64    max cycles to wait for md_done before error halt (>=2)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     synchronous reset, active-high
//  in_valid     in   1     IDU has a decoded instruction
//  in_ready     out  1     controller accepts instruction this cycle
//  in_multi     in   1     instruction uses iterative mul/div unit
//  in_ebreak    in   1     instruction is ebreak
//  in_rd        in   5     destination register index
//  in_rd_wen    in   1     destination write enable
//  alu_result   in   XLEN  combinational ALU output for accepted instr
//  md_start     out  1     one-cycle start pulse to iterative unit
//  md_abort     out  1     one-cycle abort pulse to iterative unit
//  md_done      in   1     iterative unit result valid (single-cycle pulse)
//  md_result    in   XLEN  iterative unit result, valid with md_done
//  flush        in   1     discard in-flight instruction
//  out_valid    out  1     result held for WBU
//  out_ready    in   1     WBU consumes result
//  out_result   out  XLEN  registered result
//  out_rd       out  5     registered rd
//  out_rd_wen   out  1     registered rd write enable
//  halt         out  1     sticky: core stopped
//  halt_err     out  1     sticky: halt caused by md timeout
//  ebreak_pulse out  1     one cycle high when ebreak accepted
//  retired      out  32    count of out handshakes, wraps 2^32-1 -> 0
// BEHAVIOUR
//  States: IDLE, MULTI, OUT, HALT. On rst: IDLE, all outputs 0, retired=0.
//  in_ready = (IDLE) | (OUT & out_ready). It is 0 in MULTI and HALT and during flush.
//  Accept = in_valid & in_ready. On accept, latch in_rd/in_rd_wen, then:
//   in_ebreak: go to HALT; ebreak_pulse=1 next cycle; no out_valid; not counted.
//   in_multi: go to MULTI; md_start=1 in first MULTI cycle only; timer cleared.
//   else: out_result<=alu_result; go to OUT (latency 1: out_valid next cycle).
//  MULTI: timer increments each cycle.
//   md_done: out_result<=md_result, go to OUT.
//   timer==MD_TIMEOUT-1 without md_done: go to HALT, halt_err=1, md_abort pulse.
//   md_done and timeout in the same cycle: md_done wins.
//  OUT: out_valid=1; outputs stable until out_ready. On handshake, retired++.
//   Next state is IDLE, or the new target if an accept occurs in the same cycle (back-to-back, no bubble).
//  HALT: absorbing until rst. in_ready=0, out_valid=0, md_start=0, flush ignored.
//  flush (priority below rst, above all else, except in HALT):
//   Next state IDLE; out_valid drops next cycle; no retire.
//   If in MULTI: md_abort=1 for one cycle, and late md_done is ignored.
//   flush and out handshake in the same cycle: the handshake still retires.
//  md_done outside MULTI is ignored.
//  rst mid-MULTI: no md_abort. The iterative unit shares rst.
//  halt = (state==HALT). halt_err is cleared only by rst.
// STRUCTURE
//  Package ysyx_24070016_pkg: state encoding localparams (IDLE=2'd0, MULTI=2'd1, OUT=2'd2, HALT=2'd3), XLEN.
//  Sub-module ysyx_24070016_exu_md_timer: clear/enable counter, MD_TIMEOUT compare, expire output.
//  The rest is one FSM plus the output register bank.
// TESTING
//  1 ALU op: alu_result=32'h0000_0005, rd=3, wen=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3; retired 0->1.
//  2 Back-to-back with backpressure: 3 ALU ops, out_ready low 2 cycles on the 1st.
//    -> out_result held stable; in_ready=0 while stalled; results in order; retired=3; no bubble once out_ready=1.
//  3 Multi-cycle: in_multi=1; md_done after 5 cycles with 32'hDEAD_BEEF.
//    -> md_start exactly 1 cycle; out_valid the cycle after md_done, out_result=DEADBEEF.
//  4 Timeout: MD_TIMEOUT=8, md_done never asserted -> after 8 MULTI cycles halt=1, halt_err=1, md_abort 1 cycle; in_ready stays 0.
//  5 Flush in MULTI at cycle 2, md_done arrives at cycle 3 -> md_abort 1 cycle; state IDLE; no out_valid; retired unchanged.
//  6 ebreak accepted -> ebreak_pulse 1 cycle, halt=1, out_valid never set; later flush/in_valid ignored; rst returns to IDLE with retired=0.

Source files
------------

// File: rtl/ysyx_24070016_pkg.sv
// Shared constants for the EXU sequencer: datapath width and FSM state encoding.
package ysyx_24070016_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MULTI = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/ysyx_24070016_exu_md_timer.sv
// Watchdog for the iterative mul/div unit: counts cycles while enabled and
// flags the last allowed cycle before the controller gives up.
module ysyx_24070016_exu_md_timer #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The controller leaves MULTI on expiry, so the counter never needs to wrap.
  assign expire = enable && (count == TW'(MD_TIMEOUT - 1));

endmodule

// File: rtl/ysyx_24070016_exu_ctrl.sv
// Valid/ready sequencer around the EXU datapath: single-cycle ALU ops, iterative
// mul/div hand-off with watchdog, ebreak halt and retired-instruction counter.
//   state | meaning
//   IDLE  | no instruction held, ready to accept
//   MULTI | waiting on the iterative unit (watchdog running)
//   OUT   | result held for WBU until out_ready
//   HALT  | core stopped, absorbing until rst
module ysyx_24070016_exu_ctrl #(
  parameter int XLEN       = ysyx_24070016_pkg::XLEN,
  parameter int MD_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_multi,
  input  logic            in_ebreak,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic [XLEN-1:0] alu_result,
  output logic            md_start,
  output logic            md_abort,
  input  logic            md_done,
  input  logic [XLEN-1:0] md_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic            halt,
  output logic            halt_err,
  output logic            ebreak_pulse,
  output logic [31:0]     retired
);

  import ysyx_24070016_pkg::*;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] accept_target;
  logic       accept;
  logic       retire_hs;
  logic       expire;
  logic       done_hit;
  logic       timeout_hit;

  ysyx_24070016_exu_md_timer #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state == ST_MULTI),
    .expire(expire)
  );

  always_comb begin
    in_ready      = ((state == ST_IDLE) || ((state == ST_OUT) && out_ready)) && !flush;
    accept        = in_valid && in_ready;
    retire_hs     = (state == ST_OUT) && out_ready;
    done_hit      = (state == ST_MULTI) && !flush && md_done;
    timeout_hit   = (state == ST_MULTI) && !flush && !md_done && expire;
    accept_target = in_ebreak ? ST_HALT : (in_multi ? ST_MULTI : ST_OUT);
  end

  always_comb begin
    state_nxt = state;
    if (state != ST_HALT && flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = accept_target;
        ST_MULTI: begin
          if (done_hit)         state_nxt = ST_OUT;
          else if (timeout_hit) state_nxt = ST_HALT;
        end
        ST_OUT: begin
          if (accept)         state_nxt = accept_target;
          else if (out_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      md_start     <= 1'b0;
      md_abort     <= 1'b0;
      ebreak_pulse <= 1'b0;
      halt_err     <= 1'b0;
      retired      <= '0;
      out_result   <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
    end else begin
      state        <= state_nxt;
      md_start     <= accept && !in_ebreak && in_multi;
      md_abort     <= ((state == ST_MULTI) && flush) || timeout_hit;
      ebreak_pulse <= accept && in_ebreak;
      if (timeout_hit) halt_err <= 1'b1;
      // A handshake coinciding with flush still counts as retired.
      if (retire_hs) retired <= retired + 32'd1;
      if (accept) begin
        out_rd     <= in_rd;
        out_rd_wen <= in_rd_wen;
        if (!in_ebreak && !in_multi) out_result <= alu_result;
      end
      if (done_hit) out_result <= md_result;
    end
  end

  assign out_valid = (state == ST_OUT);
  assign halt      = (state == ST_HALT);

endmodule

// File: tb/tb_ysyx_24070016_exu_ctrl.sv
// Directed bench for the EXU sequencer: ALU path, backpressure, mul/div hand-off,
// watchdog expiry, flush and ebreak halt.
module tb_ysyx_24070016_exu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_multi, in_ebreak, in_rd_wen;
  logic [4:0]  in_rd, out_rd;
  logic [31:0] alu_result, md_result, out_result, retired;
  logic        md_start, md_abort, md_done, flush;
  logic        out_valid, out_ready, out_rd_wen, halt, halt_err, ebreak_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24070016_exu_ctrl #(.XLEN(32), .MD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_multi(in_multi), .in_ebreak(in_ebreak),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .alu_result(alu_result),
    .md_start(md_start), .md_abort(md_abort), .md_done(md_done), .md_result(md_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .halt(halt), .halt_err(halt_err),
    .ebreak_pulse(ebreak_pulse), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic multi, input logic ebrk,
                          input logic [4:0] rd, input logic [31:0] alu);
    in_valid = v; in_multi = multi; in_ebreak = ebrk;
    in_rd = rd; in_rd_wen = 1'b1; alu_result = alu;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_multi = 0; in_ebreak = 0; in_rd = 0; in_rd_wen = 0;
    alu_result = 0; md_done = 0; md_result = 0; flush = 0; out_ready = 0;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_halt_err", halt_err, 0);
    check("rst_retired", retired, 0);
    check("rst_out_result", out_result, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: single ALU op, latency 1
    out_ready = 1;
    drive_op(1, 0, 0, 5'd3, 32'h0000_0005);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_result", out_result, 32'h5);
    check("t1_out_rd", out_rd, 3);
    check("t1_out_rd_wen", out_rd_wen, 1);
    check("t1_retired_pre", retired, 0);
    step();
    check("t1_out_valid_drop", out_valid, 0);
    check("t1_retired", retired, 1);

    // 2: three back-to-back ops, first one stalled for two cycles
    out_ready = 0;
    drive_op(1, 0, 0, 5'd1, 32'd11);
    step();
    drive_op(1, 0, 0, 5'd2, 32'd22);
    check("t2_stall1_in_ready", in_ready, 0);
    check("t2_stall1_result", out_result, 32'd11);
    step();
    check("t2_stall2_valid", out_valid, 1);
    check("t2_stall2_result", out_result, 32'd11);
    check("t2_stall2_in_ready", in_ready, 0);
    out_ready = 1;
    #1;
    check("t2_release_in_ready", in_ready, 1);
    step();
    drive_op(1, 0, 0, 5'd4, 32'd33);
    check("t2_b_valid", out_valid, 1);
    check("t2_b_result", out_result, 32'd22);
    check("t2_b_rd", out_rd, 2);
    check("t2_b_retired", retired, 2);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t2_c_valid", out_valid, 1);
    check("t2_c_result", out_result, 32'd33);
    check("t2_c_rd", out_rd, 4);
    check("t2_c_retired", retired, 3);
    step();
    check("t2_done_valid", out_valid, 0);
    check("t2_retired", retired, 4);

    // 3: multi-cycle op, md_done in the fifth MULTI cycle
    drive_op(1, 1, 0, 5'd5, 32'h0);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t3_md_start", md_start, 1);
    check("t3_in_ready", in_ready, 0);
    check("t3_valid_c1", out_valid, 0);
    for (int i = 2; i <= 5; i++) begin
      step();
      check($sformatf("t3_md_start_c%0d", i), md_start, 0);
      check($sformatf("t3_valid_c%0d", i), out_valid, 0);
    end
    md_done = 1; md_result = 32'hDEAD_BEEF;
    step();
    md_done = 0; md_result = 0;
    check("t3_out_valid", out_valid, 1);
    check("t3_out_result", out_result, 32'hDEAD_BEEF);
    check("t3_out_rd", out_rd, 5);
    check("t3_halt_err", halt_err, 0);
    step();
    check("t3_retired", retired, 5);

    // 5: flush in MULTI cycle 2, late md_done in cycle 3 ignored
    drive_op(1, 1, 0, 5'd6, 32'h0);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    step();
    flush = 1;
    #1;
    check("t5_flush_in_ready", in_ready, 0);
    step();
    flush = 0; md_done = 1; md_result = 32'h1234_5678;
    check("t5_md_abort", md_abort, 1);
    check("t5_valid_a", out_valid, 0);
    step();
    md_done = 0;
    check("t5_md_abort_drop", md_abort, 0);
    check("t5_valid_b", out_valid, 0);
    check("t5_retired", retired, 5);
    check("t5_in_ready_idle", in_ready, 1);

    // flush coinciding with an out handshake still retires
    drive_op(1, 0, 0, 5'd7, 32'd77);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    flush = 1;
    step();
    flush = 0;
    check("fl_hs_valid", out_valid, 0);
    check("fl_hs_retired", retired, 6);

    // md_done on the timeout cycle (8th MULTI cycle) wins
    drive_op(1, 1, 0, 5'd8, 32'h0);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    for (int i = 2; i <= 8; i++) step();
    md_done = 1; md_result = 32'h0000_0099;
    step();
    md_done = 0;
    check("race_valid", out_valid, 1);
    check("race_result", out_result, 32'h99);
    check("race_halt", halt, 0);
    check("race_md_abort", md_abort, 0);
    step();
    check("race_retired", retired, 7);

    // 4: watchdog expiry after 8 MULTI cycles
    drive_op(1, 1, 0, 5'd9, 32'h0);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4_halt_c%0d", i), halt, 0);
      check($sformatf("t4_abort_c%0d", i), md_abort, 0);
      step();
    end
    check("t4_halt", halt, 1);
    check("t4_halt_err", halt_err, 1);
    check("t4_md_abort", md_abort, 1);
    check("t4_in_ready", in_ready, 0);
    drive_op(1, 0, 0, 5'd1, 32'd1);
    flush = 1;
    step();
    flush = 0;
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t4_md_abort_drop", md_abort, 0);
    check("t4_halt_sticky", halt, 1);
    check("t4_err_sticky", halt_err, 1);
    check("t4_no_valid", out_valid, 0);
    check("t4_retired", retired, 7);
    do_reset();
    check("t4_rst_halt", halt, 0);
    check("t4_rst_err", halt_err, 0);
    check("t4_rst_retired", retired, 0);

    // 6: ebreak halts, later traffic ignored, rst recovers
    drive_op(1, 0, 1, 5'd2, 32'd5);
    check("t6_in_ready", in_ready, 1);
    step();
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t6_ebreak_pulse", ebreak_pulse, 1);
    check("t6_halt", halt, 1);
    check("t6_valid", out_valid, 0);
    check("t6_md_start", md_start, 0);
    step();
    check("t6_pulse_drop", ebreak_pulse, 0);
    check("t6_halt_err", halt_err, 0);
    flush = 1;
    drive_op(1, 0, 0, 5'd3, 32'd9);
    step();
    flush = 0;
    drive_op(0, 0, 0, 5'd0, 32'h0);
    check("t6_halt_hold", halt, 1);
    check("t6_valid_hold", out_valid, 0);
    check("t6_retired", retired, 0);
    do_reset();
    check("t6_rst_halt", halt, 0);
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_retired", retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
